range_arith_seq: RTL and testbench
==================================

// Module: range_arith_seq
// PURPOSE
//   Multi-cycle, parametrised arithmetic unit: remainder, quotient, range sum and range average of two
//   unsigned operands, selected by sel. Iterative datapath (one add or one divide step per clock),
//   start/done handshake. Drop-in sequential successor for the lab ALU datapath; fixes endless loop at op1=max.
// PARAMETERS
//   W    8     operand width (bits); W >= 2
//   RW   2*W   result width; holds max range sum (2^W-1)*2^W/2 without overflow
// PORTS
//   clk    in   1     single clock, rising edge
//   rst_n  in   1     asynchronous, active-low reset
//   start  in   1     request; accepted only when busy=0
//   sel    in   2     00 op0%op1, 01 sum(op0..op1), 10 avg(op0..op1), 11 op0/op1
//   op0    in   W     unsigned operand / range low bound
//   op1    in   W     unsigned operand / range high bound / divisor
//   busy   out  1     high from the cycle after start is accepted through the done cycle
//   done   out  1     one-cycle pulse: res/err valid
//   res    out  RW    result, held from done until the next accepted start
//   err    out  1     divide-by-zero or invalid range, qualified by done, held like res
// BEHAVIOUR
//   Reset (async assert, sync deassert by design): state IDLE; busy=0, done=0, res=0, err=0; internal regs 0.
//   Reset mid-operation aborts the operation; no done pulse is issued.
//   Handshake: start && !busy at edge k latches op0/op1/sel; busy=1 from k+1. start while busy ignored.
//   FSM: IDLE -> (start) CHECK -> SUM | DIV | FIN; SUM -> DIV (sel=10) or FIN (sel=01); DIV -> FIN;
//        FIN -> IDLE. FIN asserts done=1 and drops busy on the following edge.
//   CHECK (1 cycle): error detection.
//     sel 00/11 and op1==0 -> err=1, res=0, go FIN.
//     sel 10 and op0>op1 -> err=1, res=0, go FIN.
//     sel 01 and op0>op1 -> err=0, res=0, go FIN (empty sum).
//   SUM: acc (RW bits) += i; i is a W+1-bit counter from op0 to op1 inclusive, so op1=2^W-1 terminates.
//     Uses N=op1-op0+1 cycles. Count N is held in W+1 bits as the divisor for avg.
//   DIV: restoring division, 1 quotient bit per cycle, exactly RW cycles.
//     sel 00/11: dividend = zero-extended op0, divisor = op1. sel 10: dividend = acc, divisor = N.
//     res = remainder (00) or quotient (11, 10). Avg truncates toward zero.
//   Latency (start edge to done high): mod/quot: 2+RW cycles; sum: 2+N; avg: 2+N+RW; error/empty: 2.
//   All arithmetic is unsigned; no intermediate truncation (acc RW bits, remainder reg W+1 bits).
//   start asserted in the FIN cycle is ignored (busy still 1); it is accepted the cycle after.
// STRUCTURE
//   Shared package range_arith_pkg: sel encodings (SEL_MOD=2'b00, SEL_SUM=2'b01, SEL_AVG=2'b10,
//   SEL_QUO=2'b11) and FSM state encodings (IDLE, CHECK, SUM, DIV, FIN).
//   Sub-module seq_divider (params DW=RW, VW=W+1): load/step/quotient/remainder, no own FSM,
//   stepped by the parent. Top holds FSM, range accumulator, counters, output regs.
// TESTING
//   1. W=8: sel=00, op0=200, op1=7 -> done after 18 cycles, res=4, err=0.
//   2. sel=11, op0=200, op1=7 -> res=28, err=0; sel=11, op1=0 -> done after 2 cycles, err=1, res=0.
//   3. sel=01, op0=3, op1=6 -> done after 6 cycles, res=18; op0=0, op1=255 -> res=32640,
//      terminates (no hang); op0=9, op1=4 -> res=0, err=0.
//   4. sel=10, op0=3, op1=6 -> res=4 (18/4 truncated), latency 22; op0=9, op1=4 -> err=1.
//   5. start pulsed every cycle while busy -> exactly one done per accepted start; res stable
//      between done and the next accepted start.
//   6. rst_n low mid-SUM and mid-DIV -> outputs 0 immediately (async); no done; new start after
//      release gives a correct result.

Source files
------------

// File: rtl/range_arith_pkg.sv
// Shared definitions for the range arithmetic unit.
//   - operation select encodings carried on the sel port
//   - FSM state encoding used by range_arith_seq
package range_arith_pkg;

  localparam logic [1:0] SEL_MOD = 2'b00;  // op0 % op1
  localparam logic [1:0] SEL_SUM = 2'b01;  // sum(op0..op1)
  localparam logic [1:0] SEL_AVG = 2'b10;  // sum(op0..op1) / (op1-op0+1)
  localparam logic [1:0] SEL_QUO = 2'b11;  // op0 / op1

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SUM,
    DIV,
    FIN
  } state_t;

endpackage

// File: rtl/range_arith_seq_divider.sv
// seq_divider: restoring divider datapath, one quotient bit per step.
// No control of its own; the parent asserts load once, then step DW times.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        capture dividend/divisor, clear partial remainder
//   step        perform one restoring-division step
//   dividend    DW-bit unsigned dividend
//   divisor     VW-bit unsigned divisor (must be nonzero)
//   quotient    quotient value produced by the step performed this cycle
//   remainder   remainder value produced by the step performed this cycle
// quotient/remainder show the result of the step in progress, so the parent
// can capture the final answer on the same edge as the last step.
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);

  logic [DW-1:0] q_reg;   // shifts dividend bits out, quotient bits in
  logic [VW-1:0] r_reg;
  logic [VW-1:0] d_reg;
  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic          fits;

  // Partial remainder is always < divisor, so the shifted trial value needs
  // only one extra bit and the restored value fits back into VW bits.
  always_comb begin
    trial     = {r_reg, q_reg[DW-1]};
    diff      = trial - {1'b0, d_reg};
    fits      = (trial >= {1'b0, d_reg});
    remainder = fits ? diff[VW-1:0] : trial[VW-1:0];
    quotient  = {q_reg[DW-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
      r_reg <= '0;
      d_reg <= '0;
    end else if (load) begin
      q_reg <= dividend;
      r_reg <= '0;
      d_reg <= divisor;
    end else if (step) begin
      q_reg <= quotient;
      r_reg <= remainder;
    end
  end

endmodule

// File: rtl/range_arith_seq.sv
// range_arith_seq: multi-cycle unsigned remainder / quotient / range sum /
// range average unit with a start/done handshake.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       request, accepted only while busy=0
//   sel         operation select (see range_arith_pkg)
//   op0, op1    operands / range bounds / divisor
//   busy        high from the cycle after acceptance through the done cycle
//   done        one-cycle pulse, res/err valid
//   res, err    result and error flag, held until the next operation ends
module range_arith_seq
  import range_arith_pkg::*;
#(
  parameter int W  = 8,
  parameter int RW = 2 * W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    sel,
  input  logic [W-1:0]  op0,
  input  logic [W-1:0]  op1,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] res,
  output logic          err
);

  localparam int CW = $clog2(RW) + 1;
  localparam logic [W:0] ONE_N = 1;

  state_t        state_reg, state_next;
  logic [W-1:0]  op0_reg, op1_reg;
  logic [1:0]    sel_reg;
  logic [W:0]    i_reg;       // W+1 bits so the loop can step past op1 = 2^W-1
  logic [RW-1:0] acc_reg;
  logic [W:0]    n_reg;       // range length, divisor for the average
  logic [CW-1:0] div_cnt_reg;
  logic [RW-1:0] res_reg;
  logic          err_reg;

  logic [RW-1:0] acc_sum;
  logic          sum_last, div_last, range_bad;
  logic          div_load, div_step;
  logic [RW-1:0] div_dividend;
  logic [W:0]    div_divisor;
  logic [RW-1:0] div_quotient;
  logic [W:0]    div_remainder;

  assign acc_sum   = acc_reg + RW'(i_reg);
  assign sum_last  = (i_reg == {1'b0, op1_reg});
  assign div_last  = (div_cnt_reg == CW'(RW - 1));
  assign range_bad = (op0_reg > op1_reg);

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == FIN);
  assign res  = res_reg;
  assign err  = err_reg;

  always_comb begin
    state_next   = state_reg;
    div_load     = 1'b0;
    div_step     = 1'b0;
    div_dividend = RW'(op0_reg);
    div_divisor  = {1'b0, op1_reg};
    case (state_reg)
      IDLE:  if (start) state_next = CHECK;
      CHECK: begin
        if (sel_reg == SEL_MOD || sel_reg == SEL_QUO) begin
          if (op1_reg == '0) begin
            state_next = FIN;
          end else begin
            state_next = DIV;
            div_load   = 1'b1;
          end
        end else begin
          state_next = range_bad ? FIN : SUM;
        end
      end
      SUM: begin
        if (sum_last) begin
          if (sel_reg == SEL_AVG) begin
            // Load the divider with the sum including this cycle's term.
            state_next   = DIV;
            div_load     = 1'b1;
            div_dividend = acc_sum;
            div_divisor  = n_reg;
          end else begin
            state_next = FIN;
          end
        end
      end
      DIV: begin
        div_step = 1'b1;
        if (div_last) state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      op0_reg     <= '0;
      op1_reg     <= '0;
      sel_reg     <= '0;
      i_reg       <= '0;
      acc_reg     <= '0;
      n_reg       <= '0;
      div_cnt_reg <= '0;
      res_reg     <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            op0_reg <= op0;
            op1_reg <= op1;
            sel_reg <= sel;
          end
        end
        CHECK: begin
          i_reg       <= {1'b0, op0_reg};
          acc_reg     <= '0;
          n_reg       <= {1'b0, op1_reg} - {1'b0, op0_reg} + ONE_N;
          div_cnt_reg <= '0;
          if (state_next == FIN) begin
            // An empty sum is a valid zero; every other early exit is an error.
            res_reg <= '0;
            err_reg <= (sel_reg != SEL_SUM);
          end
        end
        SUM: begin
          acc_reg <= acc_sum;
          i_reg   <= i_reg + ONE_N;
          if (sum_last && sel_reg == SEL_SUM) begin
            res_reg <= acc_sum;
            err_reg <= 1'b0;
          end
        end
        DIV: begin
          div_cnt_reg <= div_cnt_reg + 1'b1;
          if (div_last) begin
            res_reg <= (sel_reg == SEL_MOD) ? RW'(div_remainder) : div_quotient;
            err_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  seq_divider #(
    .DW(RW),
    .VW(W + 1)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .step     (div_step),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quotient),
    .remainder(div_remainder)
  );

endmodule

// File: tb/tb_range_arith_seq.sv
// Directed, table-driven bench for range_arith_seq (W=8).
module tb_range_arith_seq;

  localparam int W  = 8;
  localparam int RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    sel = 2'b00;
  logic [W-1:0]  op0 = '0;
  logic [W-1:0]  op1 = '0;
  logic          busy, done, err;
  logic [RW-1:0] res;

  always #5 clk = ~clk;

  range_arith_seq #(.W(W), .RW(RW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sel  (sel),
    .op0  (op0),
    .op1  (op1),
    .busy (busy),
    .done (done),
    .res  (res),
    .err  (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    sel;
    logic [W-1:0]  op0;
    logic [W-1:0]  op1;
    logic [RW-1:0] res;
    logic          err;
    int            lat;
  } vec_t;

  vec_t vecs[16];

  // Issue one operation and wait (bounded) for done; latency counts clock
  // edges from the accepting edge up to the edge that raises done.
  task automatic run_op(input string tag, input logic [1:0] s, input logic [W-1:0] a,
                        input logic [W-1:0] b, output int lat, output logic [RW-1:0] r,
                        output logic e);
    int busy_bad;
    busy_bad = 0;
    lat = 0;
    @(negedge clk);
    start = 1'b1; sel = s; op0 = a; op1 = b;
    for (int c = 1; c <= 1000; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (!busy) busy_bad++;
      if (done) begin
        lat = c;
        break;
      end
    end
    r = res;
    e = err;
    check({tag, " busy_during_op"}, busy_bad, 0);
    @(posedge clk); #1;
    check({tag, " done_single_pulse"}, done, 0);
    check({tag, " busy_after_done"}, busy, 0);
    check({tag, " res_held"}, res, r);
  endtask

  int            lat, d1, d2, n_done, unstable;
  logic [RW-1:0] r;
  logic          e;

  initial begin
    vecs[0]  = '{2'b00, 8'd200, 8'd7,   16'd4,     1'b0, 18};
    vecs[1]  = '{2'b11, 8'd200, 8'd7,   16'd28,    1'b0, 18};
    vecs[2]  = '{2'b11, 8'd200, 8'd0,   16'd0,     1'b1, 2};
    vecs[3]  = '{2'b01, 8'd3,   8'd6,   16'd18,    1'b0, 6};
    vecs[4]  = '{2'b01, 8'd0,   8'd255, 16'd32640, 1'b0, 258};
    vecs[5]  = '{2'b01, 8'd9,   8'd4,   16'd0,     1'b0, 2};
    vecs[6]  = '{2'b10, 8'd3,   8'd6,   16'd4,     1'b0, 22};
    vecs[7]  = '{2'b10, 8'd9,   8'd4,   16'd0,     1'b1, 2};
    vecs[8]  = '{2'b00, 8'd200, 8'd0,   16'd0,     1'b1, 2};
    vecs[9]  = '{2'b10, 8'd0,   8'd255, 16'd127,   1'b0, 274};
    vecs[10] = '{2'b00, 8'd255, 8'd255, 16'd0,     1'b0, 18};
    vecs[11] = '{2'b11, 8'd255, 8'd1,   16'd255,   1'b0, 18};
    vecs[12] = '{2'b01, 8'd5,   8'd5,   16'd5,     1'b0, 3};
    vecs[13] = '{2'b10, 8'd5,   8'd5,   16'd5,     1'b0, 19};
    vecs[14] = '{2'b11, 8'd13,  8'd4,   16'd3,     1'b0, 18};
    vecs[15] = '{2'b00, 8'd0,   8'd9,   16'd0,     1'b0, 18};

    // Reset state
    #3;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset res", res, 0);
    check("reset err", err, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      run_op(tag, vecs[i].sel, vecs[i].op0, vecs[i].op1, lat, r, e);
      $display("op vec%0d sel=%0d op0=%0d op1=%0d -> res=%0d err=%0d lat=%0d", i,
               vecs[i].sel, vecs[i].op0, vecs[i].op1, r, e, lat);
      check({tag, " res"}, r, vecs[i].res);
      check({tag, " err"}, e, vecs[i].err);
      check({tag, " latency"}, lat, vecs[i].lat);
    end

    // start held high throughout: first op uses the latched 100%7, start during
    // the done cycle is ignored, the following IDLE edge accepts 50%7.
    @(negedge clk);
    start = 1'b1; sel = 2'b00; op0 = 8'd100; op1 = 8'd7;
    d1 = 0; d2 = 0; n_done = 0; unstable = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      op0 = 8'd50;
      if (done) begin
        n_done++;
        if (d1 == 0) begin
          d1 = c;
          check("hold first res", res, 2);
        end else if (d2 == 0) begin
          d2 = c;
          check("hold second res", res, 1);
        end
      end
      if (d1 != 0 && c > d1 && c < d1 + 2 && res != 16'd2) unstable++;
      if (d1 != 0 && c == d1 + 2) start = 1'b0;
    end
    start = 1'b0;
    $display("op held-start: done at %0d and %0d, count=%0d", d1, d2, n_done);
    check("hold done count", n_done, 2);
    check("hold first latency", d1, 18);
    check("hold restart spacing", d2 - d1, 19);
    check("hold res stable", unstable, 0);

    // Reset mid-SUM with a nonzero result held
    run_op("pre_sum", 2'b01, 8'd3, 8'd6, lat, r, e);
    check("pre_sum res", r, 18);
    @(negedge clk);
    start = 1'b1; sel = 2'b01; op0 = 8'd0; op1 = 8'd255;
    @(posedge clk); #1; start = 1'b0;
    repeat (40) @(posedge clk);
    #1 check("mid_sum busy before reset", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_sum reset busy", busy, 0);
    check("mid_sum reset done", done, 0);
    check("mid_sum reset res", res, 0);
    $display("op reset mid-SUM: busy=%0d done=%0d res=%0d", busy, done, res);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-DIV with err held high
    run_op("pre_div", 2'b11, 8'd5, 8'd0, lat, r, e);
    check("pre_div err", e, 1);
    @(negedge clk);
    start = 1'b1; sel = 2'b11; op0 = 8'd200; op1 = 8'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("mid_div busy before reset", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_div reset busy", busy, 0);
    check("mid_div reset err", err, 0);
    check("mid_div reset res", res, 0);
    $display("op reset mid-DIV: busy=%0d err=%0d res=%0d", busy, err, res);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("no done after abort", n_done, 0);

    run_op("post_reset", 2'b10, 8'd3, 8'd6, lat, r, e);
    $display("op post-reset avg(3..6) -> res=%0d err=%0d lat=%0d", r, e, lat);
    check("post_reset res", r, 4);
    check("post_reset err", e, 0);
    check("post_reset latency", lat, 22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
